// File: rtl/button_event_decoder_if.sv
// Push-button pin and decoded event outputs of button_event_decoder.
interface button_event_decoder_if;
    logic       push_button;
    logic       btn_level;
    logic       short_pulse;
    logic       long_pulse;
    logic       double_pulse;
    logic [7:0] event_count;
    logic       busy;

    modport master (
        output push_button,
        input  btn_level, short_pulse, long_pulse, double_pulse, event_count, busy
    );

    modport slave (
        input  push_button,
        output btn_level, short_pulse, long_pulse, double_pulse, event_count, busy
    );
endinterface

// File: rtl/button_event_decoder.sv
// Synchronises and debounces a push-button, then classifies presses into
// short / long / double one-cycle pulses with a wrapping event counter.
module button_event_decoder #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned LONG_CYC     = 80_000_000,
    parameter int unsigned GAP_CYC      = 30_000_000,
    parameter bit          IS_PULLUP    = 1'b0
) (
    input  logic                 clk0,
    input  logic                 rst,
    button_event_decoder_if.slave btn
);

    localparam int unsigned TMAX = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        HOLD,
        WAIT_GAP,
        PRESS2
    } state_t;

    state_t        state, state_nxt;
    logic          sync1, sync2, s;
    logic          level, level_d, rise, fall;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] timer;
    logic          short_nxt, long_nxt, double_nxt;
    logic          short_q, long_q, double_q;
    logic [7:0]    count_q;

    assign s    = sync2 ^ IS_PULLUP;
    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

    always_ff @(posedge clk0) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn.push_button;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk0) begin
        if (!rst) begin
            dcnt    <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            level_d <= level;
            if (s == level) begin
                dcnt <= '0;
            end else if (dcnt == DEB_LAST) begin
                level <= ~level;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    // A rise in WAIT_GAP is tested before the timeout so it wins a same-cycle tie.
    always_comb begin
        state_nxt  = state;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_nxt = WAIT_GAP;
                end else if (timer == LONG_LAST) begin
                    long_nxt  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (fall) state_nxt = IDLE;
            end
            WAIT_GAP: begin
                if (rise) begin
                    state_nxt = PRESS2;
                end else if (timer == GAP_LAST) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PRESS2: begin
                if (fall) begin
                    double_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rst) begin
            state    <= IDLE;
            timer    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state    <= state_nxt;
            short_q  <= short_nxt;
            long_q   <= long_nxt;
            double_q <= double_nxt;
            if (short_nxt || long_nxt || double_nxt) count_q <= count_q + 8'd1;
            if (state_nxt != state) timer <= '0;
            else if (timer != '1)   timer <= timer + TW'(1);
        end
    end

    assign btn.btn_level    = level;
    assign btn.short_pulse  = short_q;
    assign btn.long_pulse   = long_q;
    assign btn.double_pulse = double_q;
    assign btn.event_count  = count_q;
    assign btn.busy         = (state != IDLE);

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with a timestamp-based press model
// checked every cycle, plus hand-computed latency and count expectations.
module tb_button_event_decoder;

    localparam int unsigned D = 4;
    localparam int unsigned L = 50;
    localparam int unsigned G = 20;

    logic clk0 = 1'b0;
    logic rst;

    button_event_decoder_if bus ();

    always #5 clk0 = ~clk0;

    button_event_decoder #(
        .DEBOUNCE_CYC(D),
        .LONG_CYC    (L),
        .GAP_CYC     (G),
        .IS_PULLUP   (1'b0)
    ) dut (
        .clk0(clk0),
        .rst (rst),
        .btn (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int drive_cyc = 0;

    // Observed DUT pulses: totals and the cycle of the latest one
    int n_short = 0, n_long = 0, n_double = 0;
    int t_short = 0, t_long = 0, t_double = 0;

    // Model state
    logic         pin_q1 = 1'b0, pin_q2 = 1'b0;
    logic [D-1:0] s_win  = '0;
    logic         m_level = 1'b0, m_prev = 1'b0;
    logic         press_open = 1'b0, press_second = 1'b0, long_done = 1'b0;
    logic         gap_open = 1'b0;
    int           press_start = 0, gap_deadline = 0;
    logic         e_short = 1'b0, e_long = 1'b0, e_double = 1'b0, e_busy = 1'b0;
    logic [7:0]   m_count = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk0) begin
        logic rise_s, fall_s;
        cyc++;
        if (!rst) begin
            pin_q1 = 1'b0; pin_q2 = 1'b0; s_win = '0;
            m_level = 1'b0; m_prev = 1'b0;
            press_open = 1'b0; press_second = 1'b0; long_done = 1'b0; gap_open = 1'b0;
            e_short = 1'b0; e_long = 1'b0; e_double = 1'b0; e_busy = 1'b0;
            m_count = '0;
        end else begin
            rise_s = m_level & ~m_prev;
            fall_s = ~m_level & m_prev;
            e_short = 1'b0; e_long = 1'b0; e_double = 1'b0;
            if (gap_open && rise_s && cyc <= gap_deadline) begin
                gap_open = 1'b0; press_open = 1'b1; press_second = 1'b1;
            end else if (gap_open && cyc == gap_deadline) begin
                gap_open = 1'b0; e_short = 1'b1;
            end else if (rise_s) begin
                press_open = 1'b1; press_second = 1'b0; long_done = 1'b0; press_start = cyc;
            end
            if (fall_s && press_open) begin
                press_open = 1'b0;
                if (press_second) e_double = 1'b1;
                else if (!long_done) begin
                    gap_open = 1'b1; gap_deadline = cyc + G;
                end
            end else if (press_open && !press_second && !long_done && cyc == press_start + L) begin
                e_long = 1'b1; long_done = 1'b1;
            end
            m_count = m_count + 8'(e_short) + 8'(e_long) + 8'(e_double);
            e_busy  = press_open | gap_open;
            // Level flips once the last D synchronised samples all disagree with it
            s_win  = {s_win[D-2:0], pin_q2};
            m_prev = m_level;
            if (&(s_win ^ {D{m_level}})) m_level = ~m_level;
            pin_q2 = pin_q1;
            pin_q1 = bus.push_button;
        end
        #1;
        if (bus.short_pulse  === 1'b1) begin n_short++;  t_short  = cyc; end
        if (bus.long_pulse   === 1'b1) begin n_long++;   t_long   = cyc; end
        if (bus.double_pulse === 1'b1) begin n_double++; t_double = cyc; end
        chk("btn_level",    32'(bus.btn_level),    32'(m_level));
        chk("short_pulse",  32'(bus.short_pulse),  32'(e_short));
        chk("long_pulse",   32'(bus.long_pulse),   32'(e_long));
        chk("double_pulse", 32'(bus.double_pulse), 32'(e_double));
        chk("event_count",  32'(bus.event_count),  32'(m_count));
        chk("busy",         32'(bus.busy),         32'(e_busy));
    end

    // Pin is changed on a falling edge and stays for n rising edges
    task automatic drive(input logic v, input int n);
        @(negedge clk0);
        bus.push_button = v;
        drive_cyc = cyc;
        repeat (n - 1) @(negedge clk0);
    endtask

    initial begin
        int s0, l0, d0, mark;
        rst = 1'b0;
        bus.push_button = 1'b0;
        repeat (3) @(negedge clk0);
        rst = 1'b1;

        // Idle pin
        drive(1'b0, 100);
        chk("t1_count", 32'(bus.event_count), 32'd0);
        chk("t1_busy",  32'(bus.busy), 32'd0);
        chk("t1_pulses", 32'(n_short + n_long + n_double), 32'd0);

        // Short press: release sampled at +1, level falls +6, gap expires +26
        drive(1'b1, 10);
        drive(1'b0, 40);
        mark = drive_cyc;
        chk("t2_short_lat", 32'(t_short - mark), 32'd27);
        chk("t2_nshort", 32'(n_short), 32'd1);
        chk("t2_nother", 32'(n_long + n_double), 32'd0);
        chk("t2_count", 32'(bus.event_count), 32'd1);

        // Glitches shorter than the debounce window
        s0 = n_short; l0 = n_long; d0 = n_double;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3);
            drive(1'b0, 3);
        end
        drive(1'b0, 20);
        chk("t3_level", 32'(bus.btn_level), 32'd0);
        chk("t3_pulses", 32'((n_short - s0) + (n_long - l0) + (n_double - d0)), 32'd0);
        chk("t3_busy", 32'(bus.busy), 32'd0);

        // Long press
        s0 = n_short; l0 = n_long; d0 = n_double;
        drive(1'b1, 70);
        mark = drive_cyc;
        drive(1'b0, 40);
        chk("t4_long_lat", 32'(t_long - mark), 32'd57);
        chk("t4_nlong", 32'(n_long - l0), 32'd1);
        chk("t4_nother", 32'((n_short - s0) + (n_double - d0)), 32'd0);
        chk("t4_count", 32'(bus.event_count), 32'd2);

        // Double press within the gap
        s0 = n_short; d0 = n_double;
        drive(1'b1, 8);
        mark = drive_cyc;
        drive(1'b0, 10);
        drive(1'b1, 8);
        drive(1'b0, 40);
        chk("t5_double_lat", 32'(t_double - mark), 32'd33);
        chk("t5_ndouble", 32'(n_double - d0), 32'd1);
        chk("t5_nshort", 32'(n_short - s0), 32'd0);
        chk("t5_count", 32'(bus.event_count), 32'd3);

        // Gap too long: two independent shorts
        s0 = n_short; d0 = n_double;
        drive(1'b1, 8);
        drive(1'b0, 25);
        drive(1'b1, 8);
        drive(1'b0, 40);
        chk("t5b_nshort", 32'(n_short - s0), 32'd2);
        chk("t5b_ndouble", 32'(n_double - d0), 32'd0);
        chk("t5b_count", 32'(bus.event_count), 32'd5);

        // Fill counter to 255, then wrap
        for (int i = 0; i < 250; i++) begin
            drive(1'b1, 6);
            drive(1'b0, 30);
        end
        chk("t6_count255", 32'(bus.event_count), 32'd255);
        drive(1'b1, 6);
        drive(1'b0, 30);
        chk("t6_wrap", 32'(bus.event_count), 32'd0);

        // Reset during PRESS1
        drive(1'b1, 10);
        chk("t6_busy_press", 32'(bus.busy), 32'd1);
        @(negedge clk0);
        rst = 1'b0;
        bus.push_button = 1'b0;
        @(negedge clk0);
        chk("t6_busy_rst", 32'(bus.busy), 32'd0);
        chk("t6_level_rst", 32'(bus.btn_level), 32'd0);
        rst = 1'b1;
        s0 = n_short; l0 = n_long; d0 = n_double;
        drive(1'b0, 100);
        chk("t6_post_pulses", 32'((n_short - s0) + (n_long - l0) + (n_double - d0)), 32'd0);
        chk("t6_post_count", 32'(bus.event_count), 32'd0);
        chk("t6_post_busy", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
